niu_tx: RTL and testbench

Transmit-side network-interface stage placed between the user TX AXI-Stream and the 10G MAC's `tx_axis` port, all in the 156.25 MHz core clock domain. It is the counterpart of `niu_rx`: it optionally overwrites the Ethernet source MAC with the local `mac_id` and zero-pads runt frames to the 60-byte minimum. The MAC appends the FCS. It also flags frames that are errored or oversize so that the MAC aborts them, and it keeps frame, pad and error counters.

---
 rtl/niu_tx.sv | 240 ++++++++++++++++++++++++
 tb/tb_niu_tx.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/niu_tx.sv
// niu_tx: transmit-side network-interface stage between the user TX stream
// and the 10G MAC. It overwrites the source MAC with the local id, zero-pads
// runt frames to the minimum length, flags errored or oversize frames on the
// last beat so the MAC aborts them, and keeps frame/pad/error counters.
//
// state | meaning
// SOF   | waiting for the first beat of a frame
// BODY  | passing beats after the first
// PAD   | emitting zero beats until beat index 7 has gone out
module niu_tx #(
  parameter int MIN_FRAME_BYTES = 60,
  parameter int MAX_FRAME_BYTES = 1514
) (
  input  logic        user_clk,
  input  logic        reset,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        s_axis_tready,
  input  logic        mac_id_insert_en,
  input  logic        mac_id_valid,
  input  logic [47:0] mac_id,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic        m_axis_tready,
  output logic [31:0] tx_frame_count,
  output logic [31:0] tx_pad_count,
  output logic [31:0] tx_err_count
);

  typedef enum logic [1:0] {
    SOF  = 2'd0,
    BODY = 2'd1,
    PAD  = 2'd2
  } state_t;

  localparam logic [15:0] MIN_BYTES = 16'(MIN_FRAME_BYTES);
  localparam logic [15:0] MAX_BYTES = 16'(MAX_FRAME_BYTES);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] bytes_q, bytes_d;
  logic        ins_q, ins_d;
  logic        err_q, err_d;

  logic        out_free;
  logic        accept;
  logic [3:0]  keep_bytes;
  logic [2:0]  beat_idx;
  logic [2:0]  idx_inc;
  logic [16:0] byte_sum;
  logic [15:0] byte_total;
  logic        runt;
  logic        ins_cur;
  logic        err_cur;
  logic [63:0] lane_mask;
  logic [63:0] beat_data;

  logic        load;
  logic [63:0] load_data;
  logic [7:0]  load_keep;
  logic        load_last;
  logic        load_user;
  logic        load_pad;
  logic        out_pad_q;
  logic        fire_last;

  // The output register can take a new beat when it is empty or draining.
  assign out_free      = !m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = !reset & (state_q != PAD) & out_free;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign fire_last     = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // Number of valid bytes on the current beat (tkeep is contiguous from lane 0).
  always_comb begin
    keep_bytes = '0;
    for (int i = 0; i < 8; i++) begin
      keep_bytes = keep_bytes + {3'd0, s_axis_tkeep[i]};
    end
  end

  // Per-beat datapath: byte count, runt/oversize decision, lane zeroing, MAC overwrite.
  always_comb begin
    beat_idx   = (state_q == SOF) ? 3'd0 : idx_q;
    idx_inc    = (beat_idx == 3'd7) ? 3'd7 : beat_idx + 3'd1;
    byte_sum   = {1'b0, ((state_q == SOF) ? 16'd0 : bytes_q)}
               + (s_axis_tlast ? {13'd0, keep_bytes} : 17'd8);
    byte_total = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
    runt       = s_axis_tlast && (byte_total < MIN_BYTES);
    ins_cur    = (state_q == SOF) ? (mac_id_insert_en & mac_id_valid) : ins_q;
    err_cur    = ((state_q == SOF) ? 1'b0 : err_q) | s_axis_tuser
               | (byte_total > MAX_BYTES);
    lane_mask  = '0;
    for (int i = 0; i < 8; i++) begin
      lane_mask[8*i +: 8] = {8{s_axis_tkeep[i] | !runt}};
    end
    // Zero the unused lanes of a runt first; the MAC overwrite ignores tkeep.
    beat_data = s_axis_tdata & lane_mask;
    if (ins_cur && (beat_idx == 3'd0)) begin
      beat_data[63:48] = {mac_id[39:32], mac_id[47:40]};
    end
    if (ins_cur && (beat_idx == 3'd1)) begin
      beat_data[31:0] = {mac_id[7:0], mac_id[15:8], mac_id[23:16], mac_id[31:24]};
    end
  end

  // FSM next state, frame context and the beat offered to the output register.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    bytes_d   = bytes_q;
    ins_d     = ins_q;
    err_d     = err_q;
    load      = 1'b0;
    load_data = '0;
    load_keep = '0;
    load_last = 1'b0;
    load_user = 1'b0;
    load_pad  = 1'b0;
    case (state_q)
      SOF, BODY: begin
        if (accept) begin
          load      = 1'b1;
          load_data = beat_data;
          bytes_d   = byte_total;
          ins_d     = ins_cur;
          err_d     = err_cur;
          if (!s_axis_tlast) begin
            state_d   = BODY;
            idx_d     = idx_inc;
            load_keep = 8'hFF;
          end else if (runt && (beat_idx != 3'd7)) begin
            state_d   = PAD;
            idx_d     = idx_inc;
            load_keep = 8'hFF;
          end else if (runt) begin
            // Short beat already sits at index 7: it becomes the 60-byte tail.
            state_d   = SOF;
            idx_d     = 3'd0;
            load_keep = 8'h0F;
            load_last = 1'b1;
            load_user = err_cur;
            load_pad  = 1'b1;
          end else begin
            state_d   = SOF;
            idx_d     = 3'd0;
            load_keep = s_axis_tkeep;
            load_last = 1'b1;
            load_user = err_cur;
          end
        end
      end
      PAD: begin
        if (out_free) begin
          load = 1'b1;
          if (idx_q == 3'd7) begin
            state_d   = SOF;
            idx_d     = 3'd0;
            load_keep = 8'h0F;
            load_last = 1'b1;
            load_user = err_q;
            load_pad  = 1'b1;
          end else begin
            idx_d     = idx_q + 3'd1;
            load_keep = 8'hFF;
          end
        end
      end
      default: state_d = SOF;
    endcase
  end

  // FSM state register.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      state_q <= SOF;
    end else begin
      state_q <= state_d;
    end
  end

  // Per-frame context: beat index, byte count, latched insert enable, error flag.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      idx_q   <= '0;
      bytes_q <= '0;
      ins_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      bytes_q <= bytes_d;
      ins_q   <= ins_d;
      err_q   <= err_d;
    end
  end

  // Single output stage; holds its contents while the MAC stalls.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      out_pad_q     <= 1'b0;
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= load_data;
      m_axis_tkeep  <= load_keep;
      m_axis_tlast  <= load_last;
      m_axis_tuser  <= load_user;
      out_pad_q     <= load_pad;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Statistics, counted when the frame's last beat is handed to the MAC.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      tx_frame_count <= '0;
      tx_pad_count   <= '0;
      tx_err_count   <= '0;
    end else if (fire_last) begin
      tx_frame_count <= tx_frame_count + 32'd1;
      if (out_pad_q) begin
        tx_pad_count <= tx_pad_count + 32'd1;
      end
      if (m_axis_tuser) begin
        tx_err_count <= tx_err_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_niu_tx.sv
// Bench for niu_tx: frames are described as byte arrays, the expected output
// beats are derived from them and queued, and a monitor checks every beat the
// DUT hands to the MAC, output stability under back-pressure and the counters.
`timescale 1ns/1ps
module tb_niu_tx;
  localparam int MIN_B = 60;
  localparam int MAX_B = 1514;

  logic        user_clk = 1'b0;
  logic        reset;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic        s_axis_tready;
  logic        mac_id_insert_en;
  logic        mac_id_valid;
  logic [47:0] mac_id;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        m_axis_tready;
  logic [31:0] tx_frame_count;
  logic [31:0] tx_pad_count;
  logic [31:0] tx_err_count;

  niu_tx #(.MIN_FRAME_BYTES(MIN_B), .MAX_FRAME_BYTES(MAX_B)) dut (
    .user_clk(user_clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
    .mac_id_insert_en(mac_id_insert_en), .mac_id_valid(mac_id_valid), .mac_id(mac_id),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .tx_frame_count(tx_frame_count), .tx_pad_count(tx_pad_count),
    .tx_err_count(tx_err_count)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [63:0] mask;
    logic [7:0]  keep;
    logic        last;
    logic        user;
    logic        pad;
  } beat_t;

  beat_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    exp_frames = 0;
  int    exp_pads = 0;
  int    exp_errs = 0;
  bit    cnt_pending = 0;
  bit    ready_random = 0;

  initial begin
    forever #5 user_clk = ~user_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // MAC back-pressure: always ready, or a fair coin per cycle.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge user_clk);
      #1;
      m_axis_tready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: checks counters after each completed frame, stall stability, and each beat.
  initial begin : monitor
    beat_t       e;
    bit          stalled;
    logic [63:0] h_data;
    logic [7:0]  h_keep;
    logic        h_last;
    logic        h_user;
    stalled = 0;
    forever begin
      @(negedge user_clk);
      if (reset) begin
        stalled = 0;
        cnt_pending = 0;
      end else begin
        if (cnt_pending) begin
          cnt_pending = 0;
          vectors++;
          if (tx_frame_count !== 32'(exp_frames) || tx_pad_count !== 32'(exp_pads) ||
              tx_err_count !== 32'(exp_errs)) begin
            miscompares++;
            $display("FAIL counters: got frame=%0d pad=%0d err=%0d, required frame=%0d pad=%0d err=%0d",
                     tx_frame_count, tx_pad_count, tx_err_count, exp_frames, exp_pads, exp_errs);
          end
        end
        if (stalled) begin
          vectors++;
          if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== h_data || m_axis_tkeep !== h_keep ||
              m_axis_tlast !== h_last || m_axis_tuser !== h_user) begin
            miscompares++;
            $display("FAIL stall_hold: got v=%b d=%h k=%h l=%b u=%b, required v=1 d=%h k=%h l=%b u=%b",
                     m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser,
                     h_data, h_keep, h_last, h_user);
          end
        end
        stalled = m_axis_tvalid && !m_axis_tready;
        h_data = m_axis_tdata;
        h_keep = m_axis_tkeep;
        h_last = m_axis_tlast;
        h_user = m_axis_tuser;
        if (m_axis_tvalid && m_axis_tready) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL extra_beat: got d=%h k=%h l=%b, required no beat", m_axis_tdata,
                     m_axis_tkeep, m_axis_tlast);
          end else begin
            e = exp_q.pop_front();
            if (((m_axis_tdata ^ e.data) & e.mask) !== 64'h0 || m_axis_tkeep !== e.keep ||
                m_axis_tlast !== e.last || m_axis_tuser !== e.user) begin
              miscompares++;
              $display("FAIL beat: got d=%h k=%h l=%b u=%b, required d=%h (mask %h) k=%h l=%b u=%b",
                       m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser,
                       e.data, e.mask, e.keep, e.last, e.user);
            end
            if (e.last) begin
              exp_frames++;
              if (e.pad) exp_pads++;
              if (e.user) exp_errs++;
              cnt_pending = 1;
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Present one beat and hold it until it is accepted (bounded).
  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                            input logic u, input logic en, input logic val);
    logic acc;
    s_axis_tdata = d;
    s_axis_tkeep = k;
    s_axis_tlast = l;
    s_axis_tuser = u;
    mac_id_insert_en = en;
    mac_id_valid = val;
    s_axis_tvalid = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 4000 && !acc; c++) begin
      @(negedge user_clk);
      acc = s_axis_tready;
      @(posedge user_clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got no s_axis_tready, required acceptance");
    end
  endtask

  // Build a frame of len random bytes, queue the expected MAC-side beats, drive it.
  task automatic send_frame(input int len, input int err_beat, input bit en, input bit val,
                            input bit rnd, input bit gaps);
    logic [7:0]  fb[];
    logic [7:0]  ob[];
    int          nb, rem, out_len, nob;
    bit          ins, err, runt;
    beat_t       b;
    logic [63:0] d;
    logic [7:0]  k;
    logic        e_en, e_val;
    fb = new[len];
    foreach (fb[i]) fb[i] = 8'($urandom);
    nb = (len + 7) / 8;
    rem = len - 8 * (nb - 1);
    ins = en & val;
    err = (err_beat >= 0 && err_beat < nb) || (len > MAX_B);
    runt = len < MIN_B;
    out_len = runt ? 64 : len;
    ob = new[out_len];
    foreach (ob[i]) ob[i] = (i < len) ? fb[i] : 8'h00;
    if (ins) begin
      ob[6] = mac_id[47:40];
      ob[7] = mac_id[39:32];
      if (nb >= 2) begin
        ob[8]  = mac_id[31:24];
        ob[9]  = mac_id[23:16];
        ob[10] = mac_id[15:8];
        ob[11] = mac_id[7:0];
      end
    end
    nob = (out_len + 7) / 8;
    for (int j = 0; j < nob; j++) begin
      for (int i = 0; i < 8; i++) b.data[8*i +: 8] = (8*j + i < out_len) ? ob[8*j + i] : 8'h00;
      b.mask = '1;
      b.keep = 8'hFF;
      b.last = 1'b0;
      b.user = 1'b0;
      b.pad  = 1'b0;
      if (j == nob - 1) begin
        b.last = 1'b1;
        b.user = err;
        b.pad  = runt;
        if (runt) begin
          b.keep = 8'h0F;
        end else begin
          b.keep = 8'((1 << rem) - 1);
          for (int i = 0; i < 8; i++) b.mask[8*i +: 8] = {8{b.keep[i]}};
        end
      end
      exp_q.push_back(b);
    end
    for (int j = 0; j < nb; j++) begin
      for (int i = 0; i < 8; i++) d[8*i +: 8] = (8*j + i < len) ? fb[8*j + i] : 8'($urandom);
      k = (j == nb - 1) ? 8'((1 << rem) - 1) : 8'($urandom);
      if (rnd && j > 0) begin
        e_en = 1'($urandom);
        e_val = 1'($urandom);
      end else begin
        e_en = en;
        e_val = val;
      end
      if (gaps && $urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          @(posedge user_clk);
          #1;
        end
      end
      drive_beat(d, k, (j == nb - 1), (j == err_beat), e_en, e_val);
      if (j == 0) check("first_beat_latency", m_axis_tvalid, 1'b1);
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 20000) begin
      @(posedge user_clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge user_clk);
    #1;
  endtask

  initial begin : main
    int lowc;
    int len;
    int eb;
    reset = 1'b1;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tuser = 1'b0;
    mac_id_insert_en = 1'b0;
    mac_id_valid = 1'b0;
    mac_id = 48'h021122334455;
    repeat (3) @(posedge user_clk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, 64'h0);
    check("rst_tkeep", m_axis_tkeep, 8'h0);
    check("rst_tlast_tuser", {m_axis_tlast, m_axis_tuser}, 2'b00);
    check("rst_tready", s_axis_tready, 1'b0);
    check("rst_counters", {tx_frame_count, tx_pad_count} | tx_err_count, 64'h0);
    reset = 1'b0;
    @(negedge user_clk);
    check("tready_after_release", s_axis_tready, 1'b1);
    @(posedge user_clk);
    #1;

    // 64-byte frame, insertion off: passes unchanged.
    send_frame(64, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    check("frame64_count", tx_frame_count, 32'd1);
    check("frame64_pad", tx_pad_count, 32'd0);

    // 14-byte runt: padded to 60, input stalled for six pad beats.
    send_frame(14, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    lowc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge user_clk);
      if (s_axis_tready) break;
      lowc++;
    end
    check("pad_tready_low_cycles", lowc, 6);
    @(posedge user_clk);
    #1;
    drain();
    check("runt_pad_count", tx_pad_count, 32'd1);

    // Source-MAC overwrite on, then with mac_id_valid low.
    send_frame(64, -1, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(64, -1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(5, -1, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();

    // Oversize frame and a frame with an errored beat.
    send_frame(1522, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    check("oversize_err_count", tx_err_count, 32'd1);
    send_frame(64, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    check("tuser_err_count", tx_err_count, 32'd2);

    // Reset while padding, then a clean 60-byte frame.
    send_frame(14, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge user_clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    exp_frames = 0;
    exp_pads = 0;
    exp_errs = 0;
    @(posedge user_clk);
    #1;
    check("padrst_tvalid", m_axis_tvalid, 1'b0);
    check("padrst_tdata_tkeep", {m_axis_tdata, m_axis_tkeep}, 72'h0);
    check("padrst_tready", s_axis_tready, 1'b0);
    check("padrst_frame_count", tx_frame_count, 32'd0);
    reset = 1'b0;
    @(negedge user_clk);
    check("padrst_tready_release", s_axis_tready, 1'b1);
    @(posedge user_clk);
    #1;
    send_frame(60, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();
    check("after_rst_frame", tx_frame_count, 32'd1);
    check("after_rst_pad", tx_pad_count, 32'd0);

    // Random frames under random MAC back-pressure.
    ready_random = 1'b1;
    for (int f = 0; f < 200; f++) begin
      len = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 128)) : int'($urandom_range(1, MAX_B));
      eb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, (len + 7) / 8 - 1)) : -1;
      send_frame(len, eb, 1'($urandom), 1'($urandom), 1'b1, 1'b1);
    end
    drain();
    ready_random = 1'b0;
    check("final_frame_count", tx_frame_count, 32'(exp_frames));
    check("final_pad_count", tx_pad_count, 32'(exp_pads));
    check("final_err_count", tx_err_count, 32'(exp_errs));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
